// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory access controller:
// decoded load/store opcodes, FSM states and small opcode helpers.
package mem_bus_ctrl_pkg;

    typedef enum logic [3:0] {
        MEM_OP_NOP = 4'd0,
        MEM_OP_LB  = 4'd1,
        MEM_OP_LBU = 4'd2,
        MEM_OP_LH  = 4'd3,
        MEM_OP_LHU = 4'd4,
        MEM_OP_LW  = 4'd5,
        MEM_OP_SB  = 4'd6,
        MEM_OP_SH  = 4'd7,
        MEM_OP_SW  = 4'd8,
        MEM_OP_LL  = 4'd9,
        MEM_OP_SC  = 4'd10
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // Ops that drive a write cycle on the bus (SC writes when it succeeds).
    function automatic logic op_is_write(mem_op_e op);
        return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW, MEM_OP_SC};
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Registered req/ack data bus between the access controller (master)
// and the data memory (slave).
interface mem_bus_ctrl_if;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/mem_bus_ctrl_align.sv
// Big-endian byte-lane steering: lane select and replicated store data for
// the request, lane extraction with sign/zero extension for the response,
// and the alignment check.
module mem_bus_ctrl_align
    import mem_bus_ctrl_pkg::*;
(
    input  mem_op_e     op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] sdata,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte/halfword; byte 0 lives in bits [31:24].
    always_comb begin
        byte_lane = 8'h00;
        case (addr_lo)
            2'b00:   byte_lane = rdata[31:24];
            2'b01:   byte_lane = rdata[23:16];
            2'b10:   byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Decode lanes, store replication, load extension and alignment per op.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        sel        = 4'b0000;
        wdata      = sdata;
        rdata_ext  = rdata;
        misaligned = 1'b0;
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
                sel       = 4'b1000 >> addr_lo;
                wdata     = {4{sdata[7:0]}};
                rdata_ext = (op == MEM_OP_LB) ? {{24{byte_lane[7]}}, byte_lane}
                                              : {24'h000000, byte_lane};
            end
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
                misaligned = addr_lo[0];
                sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata      = {2{sdata[15:0]}};
                rdata_ext  = (op == MEM_OP_LH) ? {{16{half_lane[15]}}, half_lane}
                                               : {16'h0000, half_lane};
            end
            MEM_OP_LW, MEM_OP_SW, MEM_OP_LL, MEM_OP_SC: begin
                misaligned = |addr_lo;
                sel        = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage data-memory access controller: issues one load/store per
// instruction on the req/ack bus, stalls the pipeline until the result is
// ready, and produces the load result / SC flag and LLbit update for mem_wb.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  mem_op_e       mem_op,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_sdata,
    input  logic          LLbit_in,
    input  logic          flush,
    output logic [31:0]   rdata_o,
    output logic          stallreq,
    output logic          excp_adel,
    output logic          excp_ades,
    output logic          LLbit_we,
    output logic          LLbit_value,
    mem_bus_ctrl_if.master bus
);

    state_e      state, state_nxt;
    mem_op_e     op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] result_q;

    mem_op_e     al_op;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_sel;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata_ext;
    logic        al_misaligned;
    logic        sc_fail;
    logic        start;

    // In IDLE the aligner decodes the incoming op; afterwards it works on the
    // op latched at issue, so the response is extended for the right lane.
    assign al_op      = (state == ST_IDLE) ? mem_op        : op_q;
    assign al_addr_lo = (state == ST_IDLE) ? mem_addr[1:0] : addr_lo_q;

    mem_bus_ctrl_align u_align (
        .op         (al_op),
        .addr_lo    (al_addr_lo),
        .sdata      (mem_sdata),
        .rdata      (bus.bus_rdata),
        .sel        (al_sel),
        .wdata      (al_wdata),
        .rdata_ext  (al_rdata_ext),
        .misaligned (al_misaligned)
    );

    assign sc_fail = (mem_op == MEM_OP_SC) && !LLbit_in;
    assign start   = (state == ST_IDLE) && (mem_op != MEM_OP_NOP) &&
                     !al_misaligned && !sc_fail && !flush;

    // Next state plus the combinational pipeline-side outputs.
    always_comb begin
        state_nxt   = state;
        stallreq    = 1'b0;
        excp_adel   = 1'b0;
        excp_ades   = 1'b0;
        LLbit_we    = 1'b0;
        LLbit_value = 1'b0;
        rdata_o     = 32'h0000_0000;
        case (state)
            ST_IDLE: begin
                excp_adel = al_misaligned && !op_is_write(mem_op);
                excp_ades = al_misaligned &&  op_is_write(mem_op);
                if (start) begin
                    stallreq  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stallreq = !flush;
                if (bus.bus_ack) begin
                    state_nxt = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                rdata_o   = (op_q == MEM_OP_SC) ? 32'h0000_0001 : result_q;
                LLbit_we  = (op_q == MEM_OP_LL) || (op_q == MEM_OP_SC);
                LLbit_value = (op_q == MEM_OP_LL);
                state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                stallreq = (mem_op != MEM_OP_NOP) && !flush;
                if (bus.bus_ack) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop updates together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered bus request: loaded at issue, held through WAIT/DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0000_0000;
            bus.bus_sel   <= 4'b0000;
            bus.bus_wdata <= 32'h0000_0000;
            op_q          <= MEM_OP_NOP;
            addr_lo_q     <= 2'b00;
        end else begin
            bus.bus_req <= (state_nxt == ST_WAIT) || (state_nxt == ST_DRAIN);
            if (start) begin
                bus.bus_we    <= op_is_write(mem_op);
                bus.bus_addr  <= {mem_addr[31:2], 2'b00};
                bus.bus_sel   <= al_sel;
                bus.bus_wdata <= al_wdata;
                op_q          <= mem_op;
                addr_lo_q     <= mem_addr[1:0];
            end
        end
    end

    // Result register: captures the extended response on a clean ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= 32'h0000_0000;
        end else if ((state == ST_WAIT) && bus.bus_ack && !flush) begin
            result_q <= al_rdata_ext;
        end
    end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Data-memory access controller for the MEM stage, directly upstream of `mem_wb`. It takes one decoded load/store per instruction and runs it on a registered req/ack data bus. It applies big-endian byte-lane steering and sign/zero extension, and handles LL/SC semantics. It stalls the pipeline until the result is ready, and its outputs feed `mem_wdata`, `mem_LLbit_we` and `mem_LLbit_value` of `mem_wb`.

## Interface
- No parameters; data and address are fixed at 32 bits.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous reset, active-low (asserted at 0).
- `mem_op` in 4: decoded op: NOP, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC.
- `mem_addr` in 32: effective byte address.
- `mem_sdata` in 32: store data (right-aligned).
- `LLbit_in` in 1: current LLbit, already forwarded from MEM/WB.
- `flush` in 1: pipeline flush.
- `rdata_o` out 32: load result, or SC flag (1 = success, 0 = fail).
- `stallreq` out 1: combinational stall request to the stall controller.
- `excp_adel` / `excp_ades` out 1 each: misaligned load / misaligned store.
- `LLbit_we` / `LLbit_value` out 1 each: LLbit update.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32 (word-aligned), `bus_sel` out 4, `bus_wdata` out 32: registered bus request.
- `bus_ack` in 1, `bus_rdata` in 32: bus response.

## Operation
- **Start condition (IDLE):** op ≠ NOP, address aligned, not a failing SC, and `flush`=0.
- **Alignment rule:** halfword ops need addr[0]=0; LW/SW/LL/SC need addr[1:0]=0.
- **Misaligned access:** no bus cycle; `excp_adel` (loads, LL) or `excp_ades` (stores, SC) is asserted combinationally; `stallreq`=0.
- **SC with LLbit_in=0:** no bus cycle; `rdata_o`=0, `stallreq`=0, `LLbit_we`=0, all combinational.
- **Byte lanes (big-endian):** addr[1:0]=00 selects `bus_sel`=1000 / bits[31:24]; 11 selects 0001 / bits[7:0]. Halfword: 00 → 1100, 10 → 0011. Word → 1111.
- **Store data:** replicated across lanes (byte ×4, half ×2).
- **Load data:** selected lane, sign-extended (LB, LH) or zero-extended (LBU, LHU); LW and LL take the full word.
- **FSM states** IDLE, WAIT, DONE, DRAIN:
  - IDLE: on start → WAIT, loading `bus_req`=1, `we`, `addr`={addr[31:2],2'b00}, `sel`, `wdata`.
  - WAIT: hold all bus outputs stable. On `bus_ack` → DONE, capturing the extended `bus_rdata` into the result register, then drop `bus_req`. If `flush`=1 with no ack → DRAIN. If `flush` and `bus_ack` arrive together → IDLE, data discarded.
  - DONE: one cycle. `rdata_o` = captured data (SC: 1). LL: `LLbit_we`=1, `LLbit_value`=1. Successful SC: `LLbit_we`=1, `LLbit_value`=0. Always → IDLE, and never re-issues the same instruction.
  - DRAIN: keep `bus_req` until `bus_ack`, discard data, → IDLE. No `LLbit_we`, no exception.
- **stallreq:** 1 in IDLE when start holds; 1 in WAIT; 0 in DONE; 1 in DRAIN only if a new non-NOP op is presented; forced to 0 when `flush`=1.
- **Reset:** state=IDLE; all bus outputs, result register, `rdata_o` and LLbit outputs = 0.
- **Reset mid-WAIT:** drops `bus_req` immediately (asynchronous). The bus slave must tolerate this.

## Timing
- **Minimum access:** 3 cycles. C0: IDLE, stallreq=1. C1: WAIT, `bus_req`=1, ack seen. C2: DONE, result valid, stallreq=0; `mem_wb` captures the result at the end of C2.
- **Slow ack:** each cycle without `bus_ack` in WAIT adds one cycle.
- **Non-bus outcomes** (NOP, misaligned access, failing SC): zero added latency.
- **Back-to-back accesses:** a new access can begin in the cycle after DONE.

## Structure
- Op encodings (`MemOpNOP` … `MemOpSC`) and state encodings go in `define.v`.
- One combinational sub-module, `mem_align`: inputs op and addr[1:0], store data and bus read data; outputs `sel`, replicated write data, extended read data and the misaligned flag.

## Test plan
- **LB sign extension:** LB at 0x1003, `bus_rdata`=0x112233F4, ack in C1 → `bus_sel`=0001; `rdata_o`=0xFFFFFFF4 in C2; stallreq pattern 1,1,0.
- **SH with wait states:** SH at 0x2002, sdata=0xABCD, ack after 3 wait cycles → `bus_addr`=0x2000, `sel`=0011, `wdata`=0xABCDABCD held stable for 4 WAIT cycles; stallreq stays 1 until DONE.
- **Misaligned LW:** LW at 0x0006 → `excp_adel`=1, `bus_req` never rises, stallreq=0.
- **LL then SC, LLbit=1:** LL at 0x40 → DONE gives `LLbit_we`=1, value=1. SC at 0x40 with `LLbit_in`=1 → bus write, `rdata_o`=1, `LLbit_we`=1, value=0.
- **SC with LLbit=0:** `rdata_o`=0 combinationally, no bus cycle.
- **Flush and reset in WAIT:** `flush` raised in WAIT with ack 2 cycles later → DRAIN, `bus_req` holds until ack, no DONE, no LLbit write. Reset pulsed (`rst`=0) in WAIT → `bus_req`=0 immediately, state=IDLE.
